// File: rtl/mult_sequencer.sv
// mult_sequencer: shift-and-add multiplication sequencer.
// Each RUN cycle it presents a shifted copy of the multiplicand on Number and
// the current multiplier bit on Enable. A downstream accumulator adds Number
// whenever Enable is high and EF is low.
// Optional build macro MULT_ZERO_SKIP_EN: leave RUN as soon as no multiplier
// ones remain, instead of always running NBits cycles.
module mult_sequencer #(
  parameter int NBits = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NBits-1:0]     Multiplicand,
  input  logic [NBits-1:0]     Multiplier,
  output logic [2*NBits-1:0]   Number,
  output logic                 Enable,
  output logic                 EF,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(NBits + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [2*NBits-1:0] mcand_sr;
  logic [NBits-1:0]   mplier_sr;
  logic [CW-1:0]      count;
  logic               last_count;
  logic               finish;
  logic               load;

  assign last_count = (count == CW'(NBits - 1));
  assign load       = start && (state != RUN);

`ifdef MULT_ZERO_SKIP_EN
  // The current bit is consumed this cycle, so only bits above it matter.
  assign finish = last_count || ((mplier_sr >> 1) == '0);
`else
  assign finish = last_count;
`endif

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: start is only honoured outside RUN.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (finish) next_state = DONE;
      DONE:    next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand shift registers and iteration counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_sr  <= '0;
      mplier_sr <= '0;
      count     <= '0;
    end else if (load) begin
      mcand_sr  <= {{NBits{1'b0}}, Multiplicand};
      mplier_sr <= Multiplier;
      count     <= '0;
    end else if (state == RUN) begin
      mcand_sr  <= {mcand_sr[2*NBits-2:0], 1'b0};
      mplier_sr <= {1'b0, mplier_sr[NBits-1:1]};
      count     <= count + CW'(1);
    end
  end

  // Outputs are decoded straight from the registers.
  always_comb begin
    Number = mcand_sr;
    Enable = mplier_sr[0];
    EF     = (state != RUN);
    busy   = (state == RUN);
    done   = (state == DONE);
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: directed scoreboard bench for mult_sequencer (NBits=8)
// with a behavioural downstream accumulator.
module tb_mult_sequencer;

  localparam int NBits = 8;

  typedef struct {
    logic [2*NBits-1:0] product;
    int                 runs;
  } exp_t;

  logic               clk;
  logic               rst;
  logic               start;
  logic [NBits-1:0]   Multiplicand;
  logic [NBits-1:0]   Multiplier;
  logic [2*NBits-1:0] Number;
  logic               Enable;
  logic               EF;
  logic               busy;
  logic               done;

  logic [2*NBits-1:0] acc;
  exp_t               exp_q[$];
  int                 checks;
  int                 errors;
  int                 run_count;

  mult_sequencer #(.NBits(NBits)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .Multiplicand (Multiplicand),
    .Multiplier   (Multiplier),
    .Number       (Number),
    .Enable       (Enable),
    .EF           (EF),
    .busy         (busy),
    .done         (done)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream accumulator: cleared when a start is accepted, adds when enabled.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (start && !busy) begin
      acc <= '0;
    end else if (!EF && Enable) begin
      acc <= acc + Number;
    end
  end

  // Expected number of RUN cycles for a given multiplier.
  function automatic int expectedRuns(input logic [NBits-1:0] b);
    int r;
    r = NBits;
`ifdef MULT_ZERO_SKIP_EN
    r = 1;
    for (int i = 0; i < NBits; i++) begin
      if (b[i]) r = i + 1;
    end
`endif
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  // Called just after a negedge; pulses start over one rising edge.
  task automatic applyStimulus(input logic [NBits-1:0] a, input logic [NBits-1:0] b,
                               input logic [2*NBits-1:0] product);
    exp_t e;
    e.product    = product;
    e.runs       = expectedRuns(b);
    Multiplicand = a;
    Multiplier   = b;
    start        = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: counts RUN cycles and checks the accumulator whenever done is seen.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      run_count = 0;
    end else begin
      if (busy) run_count++;
      if (done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_done: got done=1, expected no pending result");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("product", 32'(acc), 32'(e.product));
          checkOutput("run_cycles", 32'(run_count), 32'(e.runs));
          checkOutput("busy_in_done", 32'(busy), 32'd0);
        end
        run_count = 0;
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  // Directed stimulus sequence.
  initial begin
    logic [7:0] pat;
    checks       = 0;
    errors       = 0;
    run_count    = 0;
    rst          = 1'b0;
    start        = 1'b0;
    Multiplicand = '0;
    Multiplier   = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_Number", 32'(Number), 32'd0);
    checkOutput("rst_Enable", 32'(Enable), 32'd0);
    checkOutput("rst_EF", 32'(EF), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    #2 rst = 1'b1;
    @(negedge clk);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    // 13 x 11: Enable follows multiplier bits LSB first, done in cycle 9.
    pat = 8'b0000_1011;
    applyStimulus(8'd13, 8'd11, 16'd143);
    for (int i = 0; i < 8; i++) begin
      checkOutput("enable_13x11", 32'(Enable), 32'(pat[i]));
      checkOutput("busy_13x11", 32'(busy), 32'd1);
      @(negedge clk);
    end
    checkOutput("done_cycle9", 32'(done), 32'd1);
    @(negedge clk);
    checkOutput("idle_after_done", 32'(busy), 32'd0);
    checkOutput("ef_after_done", 32'(EF), 32'd1);
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    waitDrain();

    // 255 x 255: last RUN cycle shows multiplicand shifted by 7.
    applyStimulus(8'd255, 8'd255, 16'd65025);
    repeat (7) @(negedge clk);
    checkOutput("number_last_run", 32'(Number), 32'h7F80);
    waitDrain();

    // 5 x 6 with a stray start mid-run that must be ignored.
    applyStimulus(8'd5, 8'd6, 16'd30);
    repeat (2) @(negedge clk);
    Multiplicand = 8'd15;
    Multiplier   = 8'd15;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDrain();

    // Reset in RUN cycle 4, then a fresh 3 x 4.
    applyStimulus(8'd100, 8'd100, 16'd10000);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("midrst_EF", 32'(EF), 32'd1);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_Number", 32'(Number), 32'd0);
    checkOutput("midrst_Enable", 32'(Enable), 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("no_resume_busy", 32'(busy), 32'd0);
    applyStimulus(8'd3, 8'd4, 16'd12);
    waitDrain();

    // 2 x 3 then back-to-back 9 x 9 with start held in DONE.
    applyStimulus(8'd2, 8'd3, 16'd6);
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      @(negedge clk);
    end
    checkOutput("b2b_reached_done", 32'(done), 32'd1);
    applyStimulus(8'd9, 8'd9, 16'd81);
    checkOutput("b2b_no_idle", 32'(busy), 32'd1);
    waitDrain();

    // Operands that exercise early termination when enabled.
    applyStimulus(8'd7, 8'd3, 16'd21);
    waitDrain();
    applyStimulus(8'd7, 8'd0, 16'd0);
    waitDrain();
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 SHALL have parameter: NBits, default 8 (from Parameter_Definitions), operand width.
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  load operands and begin a multiplication.
REQ-005 SHALL have port: Multiplicand  input  NBits  unsigned multiplicand, sampled with start.
REQ-006 SHALL have port: Multiplier  input  NBits  unsigned multiplier, sampled with start.
REQ-007 SHALL have port: Number  output  2*NBits  shifted multiplicand, fed to the downstream accumulator.
REQ-008 SHALL have port: Enable  output  1  current multiplier bit; accumulator adds Number when high.
REQ-009 SHALL have port: EF  output  1  end flag; high whenever not in RUN, freezes the accumulator.
REQ-010 SHALL have port: busy  output  1  high in RUN.
REQ-011 SHALL have port: done  output  1  one-cycle pulse: accumulator holds final product.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE; internal mcand_sr (2*NBits), mplier_sr (NBits), iteration counter (clog2(NBits+1) bits).
REQ-013 SHALL, on a rising edge with start=1 in IDLE or DONE: load mcand_sr with zero-extended Multiplicand, load mplier_sr, clear counter, enter RUN.
REQ-014 SHALL ignore start while in RUN; operands and sequence unaffected.
REQ-015 SHALL drive Number=mcand_sr, Enable=mplier_sr[0], EF=(state!=RUN), busy=(state==RUN) combinationally from registers.
REQ-016 SHALL, on each RUN edge: shift mcand_sr left 1 (zero fill, MSB discarded), shift mplier_sr right 1 (zero fill), increment counter.
REQ-017 SHALL leave RUN for DONE on the edge where counter reaches NBits-1 (exactly NBits RUN cycles) unless REQ-025 applies.
REQ-018 SHALL assert done only in DONE; DONE lasts one cycle, then IDLE unless start=1 (back-to-back restart).
REQ-019 SHALL, with start sampled at edge 0 and no early termination, hold RUN for cycles 1..NBits and assert done in cycle NBits+1.
REQ-020 SHALL produce sequence such that the downstream accumulator (cleared on start, adding Number when !EF and Enable) holds Multiplicand*Multiplier, modulo 2^(2*NBits), when done=1.
REQ-021 SHALL hold all registers unchanged in IDLE and DONE except as REQ-013 requires.

Reset
REQ-022 SHALL, on rst=0 at any time including mid-RUN, asynchronously enter IDLE and clear mcand_sr, mplier_sr, counter.
REQ-023 SHALL present reset outputs: Number=0, Enable=0, EF=1, busy=0, done=0.
REQ-024 SHALL require a full new start after reset release; no partial operation resumes.

Configuration
REQ-025 SHALL, with macro MULT_ZERO_SKIP_EN defined, leave RUN for DONE on any RUN edge where mplier_sr[NBits-1:1]==0 (no remaining ones), i.e. RUN cycles = max(1, index of highest set bit of Multiplier + 1).
REQ-026 SHALL, without MULT_ZERO_SKIP_EN, always run exactly NBits RUN cycles regardless of operand values.
REQ-027 SHALL produce identical final products with or without MULT_ZERO_SKIP_EN.

Verification (NBits=8, accumulator connected)
REQ-028 SHALL cover: start, 13 x 11 -> RUN cycles 1..8, done in cycle 9, accumulator=143; Enable pattern 1,1,0,1,0,0,0,0.
REQ-029 SHALL cover: 255 x 255 -> done after 8 RUN cycles, accumulator=65025; Number in final RUN cycle=0x7F80.
REQ-030 SHALL cover: start pulse during RUN of 5 x 6 -> ignored, accumulator=30, done in cycle 9.
REQ-031 SHALL cover: rst=0 in RUN cycle 4 -> immediately EF=1, busy=0, Number=0; after release, 3 x 4 completes with 12.
REQ-032 SHALL cover: start held high in DONE of 2 x 3 (=6) with new operands 9 x 9 -> restart, no IDLE cycle, accumulator=81.
REQ-033 SHALL cover with MULT_ZERO_SKIP_EN: 7 x 3 -> 2 RUN cycles, done in cycle 3, accumulator=21; 7 x 0 -> 1 RUN cycle, accumulator=0.
